sad_block_accumulator: RTL and testbench



---
 rtl/sad_pkg.sv | 16 +
 rtl/sad_min_tracker.sv | 38 +++
 rtl/sad_block_accumulator.sv | 159 +++++++++++++++
 tb/tb_sad_block_accumulator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared constants and state encoding for the SAD block accumulator.
package sad_pkg;
  localparam int ROWS   = 8;
  localparam int ROW_W  = 11;
  localparam int CAND_W = 6;
  localparam int CNT_W  = $clog2(ROWS);
  localparam int SAD_W  = ROW_W + CNT_W;

  localparam logic [SAD_W-1:0] SAD_MAX = {SAD_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/sad_min_tracker.sv
// Running minimum of block SADs; on a tie the earlier candidate is kept.
module sad_min_tracker
  import sad_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              update,
  input  logic [SAD_W-1:0]  cand_sad,
  input  logic [CAND_W-1:0] cand_idx,
  output logic [SAD_W-1:0]  best_sad,
  output logic [CAND_W-1:0] best_cand
);

  logic [SAD_W-1:0]  best_sad_r;
  logic [CAND_W-1:0] best_cand_r;

  // Best-so-far registers; SAD_MAX start value guarantees the first block wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_sad_r  <= SAD_MAX;
      best_cand_r <= {CAND_W{1'b0}};
    end else if (clear) begin
      best_sad_r  <= SAD_MAX;
      best_cand_r <= {CAND_W{1'b0}};
    end else if (update && (cand_sad < best_sad_r)) begin
      best_sad_r  <= cand_sad;
      best_cand_r <= cand_idx;
    end else begin
      best_sad_r  <= best_sad_r;
      best_cand_r <= best_cand_r;
    end
  end

  assign best_sad  = best_sad_r;
  assign best_cand = best_cand_r;

endmodule

// File: rtl/sad_block_accumulator.sv
// Accumulates row sums into block SADs and tracks the best candidate of a search.
// Define SAD_EARLY_TERM_EN to abandon blocks whose partial sum already reaches the best.
module sad_block_accumulator
  import sad_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_search_start,
  input  logic              i_row_valid,
  input  logic [ROW_W-1:0]  i_row_sum,
  input  logic [CAND_W-1:0] i_cand_idx,
  input  logic              i_search_last,
  output logic              o_ready,
  output logic              o_sad_valid,
  output logic [SAD_W-1:0]  o_sad,
  output logic [CAND_W-1:0] o_sad_cand,
  output logic [SAD_W-1:0]  o_best_sad,
  output logic [CAND_W-1:0] o_best_cand,
`ifdef SAD_EARLY_TERM_EN
  output logic              o_prune,
`endif
  output logic              o_search_done
);

  state_t            state_r, state_next_s;
  logic [SAD_W-1:0]  acc_r;
  logic [CNT_W-1:0]  row_cnt_r;
  logic [CAND_W-1:0] cand_r;
  logic              last_r;
  logic              ready_r;
  logic              sad_valid_r;
  logic [SAD_W-1:0]  sad_r;
  logic [CAND_W-1:0] sad_cand_r;
  logic              done_r;

  logic              accept_s;
  logic              last_row_s;
  logic              first_row_s;
  logic [SAD_W-1:0]  sum_s;
  logic [CAND_W-1:0] cand_eff_s;
  logic              last_eff_s;
  logic              block_end_s;
  logic              prune_s;
  logic [SAD_W-1:0]  best_sad_s;
  logic [CAND_W-1:0] best_cand_s;

  // A row coincident with a start pulse belongs to the aborted block and is dropped.
  assign accept_s    = i_row_valid && ready_r && !i_search_start;
  assign first_row_s = (row_cnt_r == {CNT_W{1'b0}});
  assign last_row_s  = (row_cnt_r == CNT_W'(ROWS - 1));
  assign sum_s       = acc_r + SAD_W'(i_row_sum);
  assign cand_eff_s  = first_row_s ? i_cand_idx : cand_r;
  assign last_eff_s  = first_row_s ? i_search_last : last_r;
  assign block_end_s = accept_s && last_row_s;

`ifdef SAD_EARLY_TERM_EN
  assign prune_s = accept_s && !last_row_s && (sum_s >= best_sad_s);
`else
  assign prune_s = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_search_start) state_next_s = ACCUM;
        else                state_next_s = IDLE;
      end
      ACCUM: begin
        if (i_search_start)                          state_next_s = ACCUM;
        else if ((block_end_s || prune_s) && last_eff_s) state_next_s = DONE;
        else                                         state_next_s = ACCUM;
      end
      DONE: begin
        if (i_search_start) state_next_s = ACCUM;
        else                state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, accumulator, row counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {SAD_W{1'b0}};
      row_cnt_r   <= {CNT_W{1'b0}};
      cand_r      <= {CAND_W{1'b0}};
      last_r      <= 1'b0;
      ready_r     <= 1'b0;
      sad_valid_r <= 1'b0;
      sad_r       <= {SAD_W{1'b0}};
      sad_cand_r  <= {CAND_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      ready_r     <= (state_next_s == ACCUM);
      done_r      <= (state_next_s == DONE);
      sad_valid_r <= block_end_s;
      if (i_search_start || block_end_s || prune_s) begin
        acc_r     <= {SAD_W{1'b0}};
        row_cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        acc_r     <= sum_s;
        row_cnt_r <= row_cnt_r + CNT_W'(1);
      end else begin
        acc_r     <= acc_r;
        row_cnt_r <= row_cnt_r;
      end
      if (accept_s && first_row_s) begin
        cand_r <= i_cand_idx;
        last_r <= i_search_last;
      end else begin
        cand_r <= cand_r;
        last_r <= last_r;
      end
      if (block_end_s) begin
        sad_r      <= sum_s;
        sad_cand_r <= cand_eff_s;
      end else begin
        sad_r      <= sad_r;
        sad_cand_r <= sad_cand_r;
      end
    end
  end

`ifdef SAD_EARLY_TERM_EN
  logic prune_r;

  // Prune pulse tells upstream to skip to the next candidate.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) prune_r <= 1'b0;
    else          prune_r <= prune_s;
  end

  assign o_prune = prune_r;
`endif

  sad_min_tracker u_min (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (i_search_start),
    .update    (block_end_s),
    .cand_sad  (sum_s),
    .cand_idx  (cand_eff_s),
    .best_sad  (best_sad_s),
    .best_cand (best_cand_s)
  );

  assign o_ready       = ready_r;
  assign o_sad_valid   = sad_valid_r;
  assign o_sad         = sad_r;
  assign o_sad_cand    = sad_cand_r;
  assign o_best_sad    = best_sad_s;
  assign o_best_cand   = best_cand_s;
  assign o_search_done = done_r;

endmodule

// File: tb/tb_sad_block_accumulator.sv
// Scoreboard bench: a block-level reference model queues expected results, a monitor checks them.
module tb_sad_block_accumulator;
  import sad_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              row_valid = 1'b0;
  logic [ROW_W-1:0]  row_sum = '0;
  logic [CAND_W-1:0] cand_idx = '0;
  logic              search_last = 1'b0;
  logic              o_ready, o_sad_valid, o_search_done;
  logic [SAD_W-1:0]  o_sad, o_best_sad;
  logic [CAND_W-1:0] o_sad_cand, o_best_cand;
  logic              dut_prune;

  typedef struct {
    bit prune;
    int sad;
    int cand;
    int best;
    int bcand;
    bit done;
    bit chk_gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;
  int   m_best;
  int   m_bcand;

  always #5 clk = ~clk;

  sad_block_accumulator dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_search_start (start),
    .i_row_valid    (row_valid),
    .i_row_sum      (row_sum),
    .i_cand_idx     (cand_idx),
    .i_search_last  (search_last),
    .o_ready        (o_ready),
    .o_sad_valid    (o_sad_valid),
    .o_sad          (o_sad),
    .o_sad_cand     (o_sad_cand),
    .o_best_sad     (o_best_sad),
    .o_best_cand    (o_best_cand),
`ifdef SAD_EARLY_TERM_EN
    .o_prune        (dut_prune),
`endif
    .o_search_done  (o_search_done)
  );

`ifndef SAD_EARLY_TERM_EN
  assign dut_prune = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every output event must match the head of the expectation queue.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (o_sad_valid || dut_prune) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=valid%0d/prune%0d required=none", o_sad_valid, dut_prune);
        end else begin
          e = exp_q.pop_front();
          if (e.prune) begin
            chk("prune_pulse", int'(dut_prune), 1);
            chk("prune_no_valid", int'(o_sad_valid), 0);
            chk("prune_done", int'(o_search_done), int'(e.done));
          end else begin
            chk("sad", int'(o_sad), e.sad);
            chk("sad_cand", int'(o_sad_cand), e.cand);
            chk("best_sad", int'(o_best_sad), e.best);
            chk("best_cand", int'(o_best_cand), e.bcand);
            chk("search_done", int'(o_search_done), int'(e.done));
`ifdef SAD_EARLY_TERM_EN
            chk("no_prune_on_block", int'(dut_prune), 0);
`endif
            if (e.chk_gap) chk("b2b_gap", cyc - last_valid_cyc, ROWS);
          end
        end
      end else begin
        chk("spurious_done", int'(o_search_done), 0);
      end
      if (o_sad_valid) last_valid_cyc = cyc;
    end
  end

  task automatic send_row(input int v, input int c, input bit l, input bit gaps);
    bit took;
    int guard;
    took  = 1'b0;
    guard = 0;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      @(negedge clk);
      row_valid = 1'b0;
      @(posedge clk);
    end
    while (!took) begin
      @(negedge clk);
      row_valid   = 1'b1;
      row_sum     = ROW_W'(v);
      cand_idx    = CAND_W'(c);
      search_last = l;
      took        = o_ready;
      @(posedge clk);
      guard++;
      if (!took && guard > 20) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout actual=no_ready required=ready_within_20");
        took = 1'b1;
      end
    end
  endtask

  task automatic run_block(input int c, input bit l, input int rows[ROWS], input bit gaps, input bit chk_gap);
    int   partial;
    bit   pruned;
    exp_t e;
    partial = 0;
    pruned  = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      send_row(rows[r], c, l, gaps);
      partial += rows[r];
`ifdef SAD_EARLY_TERM_EN
      if (r < ROWS - 1 && partial >= m_best) begin
        pruned = 1'b1;
        e = '{prune: 1'b1, sad: 0, cand: 0, best: 0, bcand: 0, done: l, chk_gap: 1'b0};
        exp_q.push_back(e);
        break;
      end
`endif
    end
    if (!pruned) begin
      if (partial < m_best) begin
        m_best  = partial;
        m_bcand = c;
      end
      e = '{prune: 1'b0, sad: partial, cand: c, best: m_best, bcand: m_bcand, done: l, chk_gap: chk_gap};
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input bit with_row);
    @(negedge clk);
    start     = 1'b1;
    row_valid = with_row;
    row_sum   = ROW_W'(10);
    @(posedge clk);
    m_best  = int'(SAD_MAX);
    m_bcand = 0;
    #1;
    start     = 1'b0;
    row_valid = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    row_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, int'(o_ready), 0);
    chk({tag, "_sad_valid"}, int'(o_sad_valid), 0);
    chk({tag, "_done"}, int'(o_search_done), 0);
    chk({tag, "_sad"}, int'(o_sad), 0);
    chk({tag, "_sad_cand"}, int'(o_sad_cand), 0);
    chk({tag, "_best_sad"}, int'(o_best_sad), int'(SAD_MAX));
    chk({tag, "_best_cand"}, int'(o_best_cand), 0);
  endtask

  initial begin
    int rows[ROWS];
    int n;
    m_best  = int'(SAD_MAX);
    m_bcand = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Rows while idle are ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      row_valid = 1'b1;
      row_sum   = ROW_W'(777);
      chk("ready_in_idle", int'(o_ready), 0);
    end

    // Single-candidate search, then rows during DONE.
    do_start(1'b0);
    foreach (rows[i]) rows[i] = 100;
    run_block(5, 1'b1, rows, 1'b0, 1'b0);
    @(negedge clk);
    row_valid = 1'b1;
    row_sum   = ROW_W'(500);
    chk("ready_in_done", int'(o_ready), 0);
    @(negedge clk);
    row_valid = 1'b0;
    chk("ready_after_done", int'(o_ready), 0);
    chk("best_holds_after_done", int'(o_best_sad), 800);

    // Three candidates with a tie.
    do_start(1'b0);
    foreach (rows[i]) rows[i] = 50;
    run_block(1, 1'b0, rows, 1'b1, 1'b0);
    foreach (rows[i]) rows[i] = 30;
    run_block(2, 1'b0, rows, 1'b1, 1'b0);
    run_block(3, 1'b1, rows, 1'b1, 1'b0);
    go_idle();

    // Maximum row values, back-to-back blocks.
    do_start(1'b0);
    foreach (rows[i]) rows[i] = 2040;
    run_block(7, 1'b0, rows, 1'b0, 1'b0);
    run_block(8, 1'b1, rows, 1'b0, 1'b1);
    go_idle();

    // Abort after 4 rows with a row coincident with the restart.
    do_start(1'b0);
    for (int r = 0; r < 4; r++) send_row(10, 4, 1'b0, 1'b0);
    do_start(1'b1);
    foreach (rows[i]) rows[i] = 1;
    run_block(9, 1'b1, rows, 1'b0, 1'b0);
    go_idle();

    // Reset in the middle of a block.
    do_start(1'b0);
    for (int r = 0; r < 3; r++) send_row(200, 11, 1'b0, 1'b0);
    @(negedge clk);
    rst_n     = 1'b0;
    row_valid = 1'b0;
    @(negedge clk);
    check_reset("midreset");
    rst_n   = 1'b1;
    m_best  = int'(SAD_MAX);
    m_bcand = 0;

`ifdef SAD_EARLY_TERM_EN
    // Early termination: partial 300 reaches best 240 on the third row.
    do_start(1'b0);
    foreach (rows[i]) rows[i] = 30;
    run_block(1, 1'b0, rows, 1'b0, 1'b0);
    foreach (rows[i]) rows[i] = 100;
    run_block(2, 1'b0, rows, 1'b0, 1'b0);
    foreach (rows[i]) rows[i] = 30;
    run_block(3, 1'b1, rows, 1'b0, 1'b0);
    go_idle();
`endif

    // Randomized searches.
    for (int s = 0; s < 20; s++) begin
      do_start(1'b0);
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        foreach (rows[i]) rows[i] = $urandom_range(0, 2040);
        run_block($urandom_range(0, 63), (k == n - 1), rows, 1'b1, 1'b0);
      end
      go_idle();
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
